// File: rtl/crc_pkg.sv
// Shared definitions for the serial CRC generator/checker pair.
package crc_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PAYLOAD = 2'd1,
        CHECK   = 2'd2,
        REPORT  = 2'd3
    } state_t;

    localparam logic [7:0] CRC_SEED = 8'hD8;
    localparam logic [7:0] CRC_TAPS = 8'h44;

endpackage

// File: rtl/crc_lfsr.sv
// Serial CRC LFSR: data step, plain right shift for CRC readout, seed load.
module crc_lfsr #(
    parameter int                 WIDTH = 8,
    parameter logic [WIDTH-1:0]   SEED  = 8'hD8,
    parameter logic [WIDTH-1:0]   TAPS  = 8'h44
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    input  logic shift_only,
    input  logic load_seed,
    input  logic din,
    output logic lsb
);

    logic [WIDTH-1:0] lfsr_q;
    logic [WIDTH-1:0] base;
    logic [WIDTH-1:0] lfsr_d;
    logic             fb;

    // A step combined with load_seed starts from SEED, so a frame can begin
    // in the same cycle the register is being re-seeded.
    always_comb begin
        base   = load_seed ? SEED : lfsr_q;
        fb     = din ^ base[0];
        lfsr_d = lfsr_q;
        if (en && shift_only) begin
            lfsr_d = {1'b0, base[WIDTH-1:1]};
        end else if (en) begin
            lfsr_d = {fb, base[WIDTH-1:1]}
                   ^ ({1'b0, TAPS[WIDTH-2:0]} & {WIDTH{fb}});
        end else if (load_seed) begin
            lfsr_d = SEED;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lfsr_q <= SEED;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end

    assign lsb = lfsr_q[0];

endmodule

// File: rtl/crc_checker.sv
// Receive-side serial CRC checker: deserialises payload + CRC and
// reports CRC_Ok / CRC_Err / Frame_Err with a one-cycle Done pulse.
module crc_checker
    import crc_pkg::*;
#(
    parameter int                     DATA_WIDTH = 8,
    parameter int                     CRC_WIDTH  = 8,
    parameter logic [CRC_WIDTH-1:0]   SEED       = CRC_SEED,
    parameter logic [CRC_WIDTH-1:0]   TAPS       = CRC_TAPS
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  Data,
    input  logic                  Active,
    input  logic                  CRC_Valid,
    output logic [DATA_WIDTH-1:0] Data_Out,
    output logic                  Done,
    output logic                  CRC_Ok,
    output logic                  CRC_Err,
    output logic                  Frame_Err
);

    localparam int MAX_W = (DATA_WIDTH > CRC_WIDTH) ? DATA_WIDTH : CRC_WIDTH;
    localparam int CNT_W = $clog2(MAX_W + 1);

    state_t                state;
    state_t                state_n;
    logic [CNT_W-1:0]      cnt;
    logic [DATA_WIDTH-1:0] payload;
    logic                  err;

    logic lfsr_en;
    logic shift_only;
    logic load_seed;
    logic lfsr_lsb;

    logic start;
    logic pay_bit;
    logic crc_bit;
    logic report;
    logic abort;

    crc_lfsr #(
        .WIDTH (CRC_WIDTH),
        .SEED  (SEED),
        .TAPS  (TAPS)
    ) u_lfsr (
        .clk        (CLK),
        .rst_n      (RST),
        .en         (lfsr_en),
        .shift_only (shift_only),
        .load_seed  (load_seed),
        .din        (Data),
        .lsb        (lfsr_lsb)
    );

    always_comb begin
        state_n    = state;
        lfsr_en    = 1'b0;
        shift_only = 1'b0;
        load_seed  = 1'b0;
        start      = 1'b0;
        pay_bit    = 1'b0;
        crc_bit    = 1'b0;
        report     = 1'b0;
        abort      = 1'b0;
        unique case (state)
            IDLE: begin
                if (Active && CRC_Valid) begin
                    abort = 1'b1;
                end else if (Active) begin
                    start     = 1'b1;
                    lfsr_en   = 1'b1;
                    load_seed = 1'b1;
                    state_n   = PAYLOAD;
                end
            end
            PAYLOAD: begin
                if (CRC_Valid) begin
                    abort = 1'b1;
                end else if (Active) begin
                    pay_bit = 1'b1;
                    lfsr_en = 1'b1;
                    if (cnt == CNT_W'(DATA_WIDTH - 1)) begin
                        state_n = CHECK;
                    end
                end
            end
            CHECK: begin
                if (Active) begin
                    abort = 1'b1;
                end else if (CRC_Valid) begin
                    crc_bit    = 1'b1;
                    lfsr_en    = 1'b1;
                    shift_only = 1'b1;
                    if (cnt == CNT_W'(CRC_WIDTH - 1)) begin
                        state_n = REPORT;
                    end
                end
            end
            REPORT: begin
                if (Active && CRC_Valid) begin
                    abort = 1'b1;
                end else begin
                    report  = 1'b1;
                    state_n = IDLE;
                end
            end
        endcase
        if (abort) begin
            state_n   = IDLE;
            load_seed = 1'b1;
        end
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state     <= IDLE;
            cnt       <= '0;
            payload   <= '0;
            err       <= 1'b0;
            Data_Out  <= '0;
            Done      <= 1'b0;
            CRC_Ok    <= 1'b0;
            CRC_Err   <= 1'b0;
            Frame_Err <= 1'b0;
        end else begin
            state <= state_n;
            Done  <= 1'b0;
            if (abort) begin
                cnt       <= '0;
                err       <= 1'b0;
                Data_Out  <= '0;
                Done      <= 1'b1;
                CRC_Ok    <= 1'b0;
                CRC_Err   <= 1'b0;
                Frame_Err <= 1'b1;
            end else if (start) begin
                cnt                 <= CNT_W'(1);
                err                 <= 1'b0;
                payload             <= '0;
                payload[DATA_WIDTH-1] <= Data;
                Data_Out            <= '0;
                CRC_Ok              <= 1'b0;
                CRC_Err             <= 1'b0;
                Frame_Err           <= 1'b0;
            end else if (pay_bit) begin
                payload <= {Data, payload[DATA_WIDTH-1:1]};
                cnt     <= (state_n == CHECK) ? '0 : cnt + CNT_W'(1);
            end else if (crc_bit) begin
                err <= err | (Data ^ lfsr_lsb);
                cnt <= (state_n == REPORT) ? '0 : cnt + CNT_W'(1);
            end else if (report) begin
                Done     <= 1'b1;
                Data_Out <= payload;
                CRC_Ok   <= ~err;
                CRC_Err  <= err;
            end
        end
    end

endmodule

// File: tb/tb_crc_checker.sv
// Scoreboard bench for crc_checker: driver pushes expected frame results,
// a negedge monitor pops them whenever Done pulses.
module tb_crc_checker;

    localparam logic [7:0] G_SEED = 8'hD8;
    localparam logic [7:0] G_TAPS = 8'h44;

    logic       CLK = 1'b0;
    logic       RST = 1'b0;
    logic       Data = 1'b0;
    logic       Active = 1'b0;
    logic       CRC_Valid = 1'b0;
    logic [7:0] Data_Out;
    logic       Done;
    logic       CRC_Ok;
    logic       CRC_Err;
    logic       Frame_Err;

    crc_checker dut (
        .CLK       (CLK),
        .RST       (RST),
        .Data      (Data),
        .Active    (Active),
        .CRC_Valid (CRC_Valid),
        .Data_Out  (Data_Out),
        .Done      (Done),
        .CRC_Ok    (CRC_Ok),
        .CRC_Err   (CRC_Err),
        .Frame_Err (Frame_Err)
    );

    always #5 CLK = ~CLK;

    typedef struct packed {
        logic       ok;
        logic       err;
        logic       ferr;
        logic [7:0] data;
    } exp_t;

    exp_t q[$];
    int   tests = 0;
    int   fails = 0;
    logic prev_done = 1'b0;

    // Polynomial-division view of the LFSR: shift right, fold in (MSB|TAPS) on feedback.
    function automatic logic [7:0] golden_crc(input logic [7:0] p);
        logic [7:0] r;
        r = G_SEED;
        for (int i = 0; i < 8; i++) begin
            if (p[i] ^ r[0]) r = (r >> 1) ^ (8'h80 | G_TAPS);
            else             r = r >> 1;
        end
        return r;
    endfunction

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", name, act, req);
        end
    endtask

    always @(negedge CLK) begin
        if (Done === 1'b1) begin
            exp_t e;
            if (prev_done) check("done_pulse_width", 32'd2, 32'd1);
            if (q.size() == 0) begin
                check("unexpected_done", 32'd1, 32'd0);
            end else begin
                e = q.pop_front();
                check("flags", {29'd0, CRC_Ok, CRC_Err, Frame_Err},
                      {29'd0, e.ok, e.err, e.ferr});
                check("data_out", {24'd0, Data_Out}, {24'd0, e.data});
            end
        end
        prev_done = (Done === 1'b1);
    end

    task automatic drive(input logic a, input logic c, input logic d);
        @(negedge CLK);
        Active    = a;
        CRC_Valid = c;
        Data      = d;
    endtask

    task automatic idle(input int n);
        repeat (n) drive(1'b0, 1'b0, 1'b0);
    endtask

    task automatic drain();
        for (int k = 0; k < 6 && q.size() != 0; k++) @(negedge CLK);
        if (q.size() != 0) begin
            check("done_timeout", q.size(), 32'd0);
            q.delete();
        end
    endtask

    task automatic send_frame(input logic [7:0] p, input logic [7:0] crc,
                              input int maxgap);
        exp_t e;
        logic ok;
        ok     = (crc == golden_crc(p));
        e.ok   = ok;
        e.err  = ~ok;
        e.ferr = 1'b0;
        e.data = p;
        q.push_back(e);
        for (int i = 0; i < 8; i++) begin
            if (i > 0) idle($urandom_range(0, maxgap));
            drive(1'b1, 1'b0, p[i]);
        end
        for (int i = 0; i < 8; i++) begin
            idle($urandom_range(0, maxgap));
            drive(1'b0, 1'b1, crc[i]);
        end
        idle(1);
        check("done_latency_report", {31'd0, Done}, 32'd0);
        idle(1);
        check("done_latency", {31'd0, Done}, 32'd1);
        drain();
        idle(1);
    endtask

    initial begin
        logic [7:0] p;
        #1;
        check("rst_outs", {20'd0, Data_Out, Done, CRC_Ok, CRC_Err, Frame_Err},
              32'd0);
        #20;
        RST = 1'b1;
        idle(2);

        check("golden_zero", {24'd0, golden_crc(8'h00)}, 32'h14);
        send_frame(8'h00, 8'h14, 0);
        send_frame(8'h00, 8'h10, 0);
        check("sticky_err", {30'd0, CRC_Ok, CRC_Err}, 32'd1);

        for (int n = 0; n < 10; n++) begin
            p = 8'($urandom);
            send_frame(p, golden_crc(p), 3);
        end
        p = 8'($urandom);
        send_frame(p, golden_crc(p) ^ 8'h80, 2);

        // Violation at payload bit 5.
        begin
            exp_t e;
            e.ok = 1'b0; e.err = 1'b0; e.ferr = 1'b1; e.data = 8'h00;
            for (int i = 0; i < 5; i++) drive(1'b1, 1'b0, 1'b0);
            q.push_back(e);
            drive(1'b1, 1'b1, 1'b0);
            idle(1);
            check("abort_latency", {31'd0, Done}, 32'd1);
            drain();
            idle(2);
        end
        send_frame(8'h00, 8'h14, 0);

        // Reset after 4 payload bits.
        for (int i = 0; i < 4; i++) drive(1'b1, 1'b0, 1'b1);
        @(negedge CLK);
        Active = 1'b0;
        RST    = 1'b0;
        #1;
        check("midframe_rst", {20'd0, Data_Out, Done, CRC_Ok, CRC_Err, Frame_Err},
              32'd0);
        idle(2);
        RST = 1'b1;
        idle(2);
        send_frame(8'hA5, golden_crc(8'hA5), 1);

        // CRC_Valid pulses in IDLE.
        for (int i = 0; i < 5; i++) begin
            drive(1'b0, 1'b1, i[0]);
            idle(1);
        end
        idle(3);
        check("idle_crcv_flags", {20'd0, Data_Out, Done, CRC_Ok, CRC_Err,
              Frame_Err}, {20'd0, 8'hA5, 4'b0100});

        idle(2);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

endmodule
